// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU boot loader: FSM states and stream command codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    CMD,
    ADDR,
    CNT,
    DATA,
    RELEASE,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic [15:0] CMD_IMEM = 16'h0000;
  localparam logic [15:0] CMD_DMEM = 16'h0001;
  localparam logic [15:0] CMD_END  = 16'hFFFF;

endpackage

// File: rtl/cpu_mem_loader_release_timer.sv
// Counts cycles spent in RELEASE; expired holds once CYCLES cycles have elapsed.
module loader_release_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == CW'(CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!run) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/cpu_mem_loader.sv
// Boot-time stream loader: writes imem/dmem segments while holding the core in reset,
// then releases it after a short pipeline-flush delay.
module cpu_mem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  loader_state_t state_q, state_d;

  logic              tgt_dmem_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [DATA_W-1:0] rem_q;
  logic              imem_we_q, dmem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              accept;
  logic              rel_expired;

  // Gated by reset_n so in_ready reads 0 while reset is held even though state is CMD.
  assign in_ready  = reset_n && (state_q == CMD || state_q == ADDR ||
                                 state_q == CNT || state_q == DATA);
  assign accept    = in_valid && in_ready;
  assign cpu_reset = (state_q != DONE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERROR);
  assign imem_we   = imem_we_q;
  assign dmem_we   = dmem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  loader_release_timer #(
    .CYCLES(RELEASE_CYCLES)
  ) u_release_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (state_q == RELEASE),
    .expired(rel_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      CMD: begin
        if (accept) begin
          if (in_data == CMD_IMEM || in_data == CMD_DMEM) begin
            state_d = ADDR;
          end else if (in_data == CMD_END) begin
            state_d = RELEASE;
          end else begin
            state_d = ERROR;
          end
        end
      end
      ADDR:    if (accept) state_d = CNT;
      CNT:     if (accept) state_d = (in_data == '0) ? CMD : DATA;
      DATA:    if (accept && rem_q == DATA_W'(1)) state_d = CMD;
      RELEASE: if (rel_expired) state_d = DONE;
      DONE:    if (start) state_d = CMD;
      ERROR:   if (start) state_d = CMD;
      default: state_d = CMD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CMD;
    end else begin
      state_q <= state_d;
    end
  end

  // Segment bookkeeping plus the one-cycle-latency write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_dmem_q  <= 1'b0;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      imem_we_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          CMD:  tgt_dmem_q <= (in_data == CMD_DMEM);
          ADDR: cur_addr_q <= ADDR_W'(in_data);
          CNT:  rem_q <= in_data;
          DATA: begin
            imem_we_q   <= !tgt_dmem_q;
            dmem_we_q   <= tgt_dmem_q;
            mem_addr_q  <= cur_addr_q;
            mem_wdata_q <= in_data;
            cur_addr_q  <= cur_addr_q + ADDR_W'(1);
            rem_q       <= rem_q - DATA_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Scoreboard bench for cpu_mem_loader: expected writes are queued as words are accepted.
module tb_cpu_mem_loader;
  import cpu_pkg::*;

  typedef struct packed {
    logic        dm;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        start = 1'b0;
  logic        imem_we, dmem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        cpu_reset, done, error;

  int total = 0;
  int bad = 0;
  wr_t sb[$];
  wr_t exp_w;

  cpu_mem_loader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .start    (start),
    .imem_we  (imem_we),
    .dmem_we  (dmem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (reset_n && (imem_we || dmem_we)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got im=%0b dm=%0b addr=%h data=%h, required none",
                 imem_we, dmem_we, mem_addr, mem_wdata);
      end else begin
        exp_w = sb.pop_front();
        if ({dmem_we, imem_we, mem_addr, mem_wdata} !==
            {exp_w.dm, !exp_w.dm, exp_w.addr, exp_w.data}) begin
          bad++;
          $display("FAIL write: got dm=%0b im=%0b addr=%h data=%h, required dm=%0b addr=%h data=%h",
                   dmem_we, imem_we, mem_addr, mem_wdata, exp_w.dm, exp_w.addr, exp_w.data);
        end
      end
    end
  end

  // Offer one word after 'gap' idle cycles; returns just after the accepting edge.
  task automatic send(input logic [15:0] w, input int gap);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL accept_timeout: in_ready=%0b, required 1 for word %h", in_ready, w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_seg(input logic dm, input logic [15:0] base, input int cnt,
                          input int max_gap);
    logic [15:0] a;
    logic [15:0] w;
    send(dm ? CMD_DMEM : CMD_IMEM, 0);
    send(base, 0);
    send(16'(cnt), 0);
    a = base;
    for (int k = 0; k < cnt; k++) begin
      w = 16'($urandom_range(0, 16'hFFFF));
      sb.push_back('{dm: dm, addr: a, data: w});
      send(w, (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
      a = a + 16'd1;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // END, then check cpu_reset holds for 4 cycles and drops with done on the 5th.
  task automatic test_release();
    send(CMD_END, 0);
    idle();
    @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) @(posedge clk);
      #1;
      total++;
      if (cpu_reset !== (i < 5) || done !== (i == 5)) begin
        bad++;
        $display("FAIL release_c%0d: cpu_reset=%0b done=%0b, required cpu_reset=%0b done=%0b",
                 i, cpu_reset, done, i < 5, i == 5);
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending_writes: got %0d outstanding, required 0", sb.size());
    end
    pulse_start();
    #1;
    total++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rearm: cpu_reset=%0b done=%0b in_ready=%0b, required 1 0 1",
               cpu_reset, done, in_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_reset, done, error} !==
        {1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_vals: rdy=%0b iw=%0b dw=%0b a=%h d=%h cr=%0b dn=%0b er=%0b, required 0 0 0 0000 0000 1 0 0",
               in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_reset, done, error);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_imem_load();
    logic [15:0] d [3];
    d[0] = 16'h000A; d[1] = 16'h000B; d[2] = 16'h000C;
    send(CMD_IMEM, 0);
    send(16'h0010, 0);
    send(16'h0003, 0);
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{dm: 1'b0, addr: 16'h0010 + 16'(k), data: d[k]});
      send(d[k], 0);
    end
    test_release();
  endtask

  task automatic test_dmem_wrap();
    send(CMD_DMEM, 0);
    send(16'hFFFE, 0);
    send(16'h0003, 0);
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{dm: 1'b1, addr: 16'hFFFE + 16'(k), data: 16'(k + 1)});
      send(16'(k + 1), 0);
    end
    test_release();
  endtask

  task automatic test_empty_segment();
    send_seg(1'b0, 16'h1234, 0, 0);
    test_release();
  endtask

  task automatic test_random_gaps();
    send_seg(1'b0, 16'h0100, 8, 3);
    send_seg(1'b1, 16'h0200, 6, 2);
    test_release();
  endtask

  task automatic test_error();
    send(16'h0002, 0);
    idle();
    #1;
    total++;
    if (error !== 1'b1 || in_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL error_state: error=%0b in_ready=%0b cpu_reset=%0b, required 1 0 1",
               error, in_ready, cpu_reset);
    end
    pulse_start();
    #1;
    total++;
    if (error !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL error_clear: error=%0b in_ready=%0b, required 0 1", error, in_ready);
    end
  endtask

  task automatic test_reset_mid_data();
    send(CMD_IMEM, 0);
    send(16'h0040, 0);
    send(16'h0005, 0);
    sb.push_back('{dm: 1'b0, addr: 16'h0040, data: 16'h1111});
    send(16'h1111, 0);
    idle();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (dut.state_q !== CMD || imem_we !== 1'b0 || in_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: state=%0d iw=%0b rdy=%0b cr=%0b, required state=CMD 0 0 1",
               dut.state_q, imem_we, in_ready, cpu_reset);
    end
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    // After reset a CMD word is expected again, so an illegal code must trap to ERROR.
    send(16'h0003, 0);
    idle();
    #1;
    total++;
    if (error !== 1'b1) begin
      bad++;
      $display("FAIL cmd_after_reset: error=%0b, required 1", error);
    end
    pulse_start();
  endtask

  initial begin
    test_reset();
    test_imem_load();
    test_dmem_wrap();
    test_empty_segment();
    test_random_gaps();
    test_error();
    test_reset_mid_data();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
